// File: rtl/mf_cen_bank.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// with atomic shadow->active apply and a settle/lock FSM gating the enable outputs.
module mf_cen_bank #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              cfg_apply,
    output logic [NUM_CH-1:0] cen,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        SETTLE,
        LOCKED
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               locked_q;
    logic [NUM_CH-1:0]  cen_q, cen_d;

    logic [ACC_W-1:0]   inc_sh_q [NUM_CH];
    logic [ACC_W-1:0]   inc_sh_d [NUM_CH];
    logic [ACC_W-1:0]   ph_sh_q  [NUM_CH];
    logic [ACC_W-1:0]   ph_sh_d  [NUM_CH];
    logic [ACC_W-1:0]   inc_q    [NUM_CH];
    logic [ACC_W-1:0]   inc_d    [NUM_CH];
    logic [ACC_W-1:0]   acc_q    [NUM_CH];
    logic [ACC_W-1:0]   acc_d    [NUM_CH];
    logic [ACC_W:0]     sum      [NUM_CH];

    // Apply reads the pre-edge shadows, so a same-cycle write only affects the next apply.
    always_comb begin
        cen_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum[i]      = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            inc_sh_d[i] = inc_sh_q[i];
            ph_sh_d[i]  = ph_sh_q[i];
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                inc_sh_d[i] = cfg_inc;
                ph_sh_d[i]  = cfg_phase;
            end
            if (cfg_apply) begin
                inc_d[i]  = inc_sh_q[i];
                acc_d[i]  = ph_sh_q[i];
                cen_d[i]  = 1'b0;
            end else begin
                inc_d[i]  = inc_q[i];
                acc_d[i]  = sum[i][ACC_W-1:0];
                cen_d[i]  = sum[i][ACC_W] & locked_q;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cen_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                inc_sh_q[i] <= '0;
                ph_sh_q[i]  <= '0;
                inc_q[i]    <= '0;
                acc_q[i]    <= '0;
            end
        end else begin
            cen_q <= cen_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                inc_sh_q[i] <= inc_sh_d[i];
                ph_sh_q[i]  <= ph_sh_d[i];
                inc_q[i]    <= inc_d[i];
                acc_q[i]    <= acc_d[i];
            end
        end
    end

    // Accumulators keep running while settling; only the enables are held off.
    always_ff @(posedge refclk) begin
        if (rst || cfg_apply) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    locked_q <= 1'b1;
                end
            endcase
        end
    end

    assign cen    = cen_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_mf_cen_bank.sv
// Directed bench for mf_cen_bank: a closed-form carry model predicts {locked, cen}
// for two instances (default and 8-bit/5-channel) every cycle.
module tb_mf_cen_bank;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_we, a_apply, a_locked;
    logic [1:0]  a_ch;
    logic [23:0] a_inc, a_ph;
    logic [3:0]  a_cen;

    logic        b_rst, b_we, b_apply, b_locked;
    logic [2:0]  b_ch;
    logic [7:0]  b_inc, b_ph;
    logic [4:0]  b_cen;

    mf_cen_bank u_a (
        .refclk(clk), .rst(a_rst), .cfg_we(a_we), .cfg_ch(a_ch),
        .cfg_inc(a_inc), .cfg_phase(a_ph), .cfg_apply(a_apply),
        .cen(a_cen), .locked(a_locked)
    );

    mf_cen_bank #(.NUM_CH(5), .ACC_W(8), .LOCK_CYCLES(4)) u_b (
        .refclk(clk), .rst(b_rst), .cfg_we(b_we), .cfg_ch(b_ch),
        .cfg_inc(b_inc), .cfg_phase(b_ph), .cfg_apply(b_apply),
        .cen(b_cen), .locked(b_locked)
    );

    typedef struct {
        string    tag;
        int       d;
        bit [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int        NCH [2] = '{4, 5};
    int        WID [2] = '{24, 8};
    int        LCK [2] = '{16, 4};
    int        kk  [2];
    bit [31:0] act_inc [2][5];
    bit [31:0] act_p   [2][5];
    bit [31:0] sh_inc  [2][5];
    bit [31:0] sh_p    [2][5];

    // Carry on edge k after apply: floor((p+k*inc)/2^w) steps up.
    function automatic bit carry(bit [31:0] p, bit [31:0] inc, int k, int w);
        longint unsigned pa, ia, ka, x, y;
        pa = longint'(p);
        ia = longint'(inc);
        ka = longint'(k);
        x  = pa + ka * ia;
        y  = pa + (ka - 1) * ia;
        return (x >> w) != (y >> w);
    endfunction

    task automatic model_step(int d, bit r, bit we, int ch, bit [31:0] inc, bit [31:0] ph, bit ap);
        if (r) begin
            kk[d] = 0;
            for (int i = 0; i < 5; i++) begin
                act_inc[d][i] = 0; act_p[d][i] = 0;
                sh_inc[d][i]  = 0; sh_p[d][i]  = 0;
            end
        end else begin
            if (ap) begin
                kk[d] = 0;
                for (int i = 0; i < 5; i++) begin
                    act_inc[d][i] = sh_inc[d][i];
                    act_p[d][i]   = sh_p[d][i];
                end
            end else begin
                kk[d]++;
            end
            if (we && ch < NCH[d]) begin
                sh_inc[d][ch] = inc;
                sh_p[d][ch]   = ph;
            end
        end
    endtask

    function automatic bit [7:0] model_out(int d);
        bit [7:0] v;
        v = '0;
        v[NCH[d]] = (kk[d] >= LCK[d]);
        for (int i = 0; i < NCH[d]; i++)
            v[i] = (kk[d] >= LCK[d] + 1) && carry(act_p[d][i], act_inc[d][i], kk[d], WID[d]);
        return v;
    endfunction

    task automatic check_pop();
        exp_t     e;
        bit [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.d == 0) ? {3'b000, a_locked, a_cen} : {2'b00, b_locked, b_cen};
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s dut%0d k=%0d: got %h expected %h", e.tag, e.d, kk[e.d], obs, e.val);
            end
        end
    endtask

    // One clock: stimulus on dut d (the other idles), rst per dut.
    task automatic cyc(bit ra, bit rb, int d, bit we, int ch, bit [31:0] inc, bit [31:0] ph,
                       bit ap, string tag);
        a_rst = ra; b_rst = rb;
        a_we = 0; a_apply = 0; a_ch = '0; a_inc = '0; a_ph = '0;
        b_we = 0; b_apply = 0; b_ch = '0; b_inc = '0; b_ph = '0;
        if (d == 0) begin
            a_we = we; a_apply = ap; a_ch = 2'(ch); a_inc = 24'(inc); a_ph = 24'(ph);
        end else begin
            b_we = we; b_apply = ap; b_ch = 3'(ch); b_inc = 8'(inc); b_ph = 8'(ph);
        end
        model_step(0, ra, d == 0 && we, ch, inc, ph, d == 0 && ap);
        model_step(1, rb, d == 1 && we, ch, inc, ph, d == 1 && ap);
        sb.push_back('{tag, 0, model_out(0)});
        sb.push_back('{tag, 1, model_out(1)});
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic idle(int n, string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    int pulses;

    initial begin
        cyc(1, 1, 0, 0, 0, 0, 0, 0, "reset");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, "reset");
        idle(20, "lock_after_reset");

        cyc(0, 0, 0, 1, 0, 32'h800000, 0, 0, "wr_ch0");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, "apply1");
        idle(30, "half_rate");

        cyc(0, 0, 0, 1, 1, 32'h400000, 32'hC00000, 0, "wr_ch1");
        cyc(0, 0, 0, 1, 2, 32'h400000, 0, 0, "wr_ch2");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, "apply_locked");
        idle(30, "quarter_lag");

        cyc(0, 0, 0, 1, 0, 32'h200000, 0, 1, "we_with_apply");
        idle(22, "old_inc_kept");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, "apply_new");
        idle(30, "eighth_rate");

        cyc(0, 0, 1, 1, 5, 32'h55, 32'h11, 0, "wr_oob5");
        cyc(0, 0, 1, 1, 7, 32'h77, 32'h22, 0, "wr_oob7");
        cyc(0, 0, 1, 1, 0, 32'hFF, 0, 0, "b_wr_ch0");
        cyc(0, 0, 1, 0, 0, 0, 0, 1, "b_apply");
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, "b_settle");
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 0, "b_ff_rate");
            pulses += int'(b_cen[0]);
        end
        checks++;
        assert (pulses === 255) else begin
            errors++;
            $error("FAIL b_ff_count: got %0d pulses expected 255", pulses);
        end

        cyc(0, 1, 1, 0, 0, 0, 0, 0, "b_rst_mid");
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, "b_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mf_cen_bank.md
# mf_cen_bank

Parametrised multi-channel clock-enable generator, the fractional successor to the fixed 4-output PLL wrapper. It runs entirely on the PLL master clock. Per channel it produces single-cycle enable pulses at `f_clk * inc / 2^ACC_W`. Increment and start phase are runtime-programmable and are applied to all channels atomically. A lock/settle state machine gates the outputs, so every channel starts phase-coherent after a configuration change. Core timing chains such as the video and audio dividers consume `cen` instead of extra PLL outputs.

## Interface
- `NUM_CH`, 4, number of enable channels (1..16).
- `ACC_W`, 24, phase-accumulator width in bits (8..32).
- `LOCK_CYCLES`, 16, settle cycles before `locked` asserts (≥1).
- `CH_W`, `$clog2(NUM_CH)` (min 1), width of channel select. Derived; do not override.

Ports:
- `refclk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: write `cfg_inc`/`cfg_phase` into the shadow registers of channel `cfg_ch`.
- `cfg_ch` in CH_W: channel select for `cfg_we`.
- `cfg_inc` in ACC_W: increment to shadow.
- `cfg_phase` in ACC_W: start phase to shadow.
- `cfg_apply` in 1: one-cycle strobe that copies all shadows to active and restarts the settle sequence.
- `cen` out NUM_CH: registered enable pulses, one bit per channel.
- `locked` out 1: high when outputs are valid and phase-coherent.

## Operation
- Per-channel state: shadow `inc_sh`/`ph_sh`, active `inc`, and accumulator `acc`, each ACC_W bits.
- Sum per channel: `sum = {1'b0,acc} + {1'b0,inc}`, which is ACC_W+1 bits. The carry-out is `sum[ACC_W]`. The accumulator wraps modulo 2^ACC_W with no saturation.
- Normal edge (no `rst`, no `cfg_apply`):
  - `acc <= sum[ACC_W-1:0]`.
  - `cen[i] <= sum[ACC_W] & locked`, where `locked` is the pre-edge register value.
- `cfg_we` with `cfg_ch < NUM_CH` writes that channel's shadows. When `cfg_ch ≥ NUM_CH` the write is ignored and nothing changes.
- Apply edge (`cfg_apply=1`), on all channels simultaneously:
  - `inc <= inc_sh`, `acc <= ph_sh`.
  - `cen <= 0`, `locked <= 0`.
  - FSM → SETTLE, `cnt <= 0`.
- `cfg_we` and `cfg_apply` in the same cycle:
  - Apply uses the pre-edge shadow values.
  - The write still lands in the shadow and takes effect at the next apply.
- `inc = 0` makes the channel silent: it never carries.
- `inc = 2^ACC_W-1` makes the channel pulse on all edges except one per 2^ACC_W edges.
- Lock FSM, two states, with `cnt` of `$clog2(LOCK_CYCLES+1)` bits:
  - SETTLE: `cnt` increments each edge. At the edge where `cnt == LOCK_CYCLES-1`, `locked <= 1` and the FSM → LOCKED.
  - LOCKED: `locked` stays 1. `cfg_apply` → SETTLE (apply-edge rules above).
  - `cfg_apply` during SETTLE restarts `cnt` at 0.
- Accumulators keep running during SETTLE. Only `cen` is gated, so phase relationships hold when `locked` rises.

## Timing
- Reset values, on a `rst` edge with priority over everything:
  - `cen=0`, `locked=0`, all `acc`/`inc`/shadows = 0, `cnt=0`, FSM=SETTLE.
- `rst` asserted mid-operation clears all state at that edge.
- `locked` rises at the LOCK_CYCLES-th edge after the last `rst` edge or `cfg_apply` edge. Example: with LOCK_CYCLES=16 and `cfg_apply` sampled at edge E, `locked` is 1 after edge E+16.
- The first `cen` can appear after edge E+17, because gating uses the pre-edge `locked`.
- `cen` latency: 1 edge from the accumulator carry; each pulse is 1 cycle wide.
- A channel with `ph_sh = p` and increment `inc` carries for the first time on the k-th edge after apply, where k is the smallest integer with `p + k·inc ≥ 2^ACC_W`.
- `cfg_we` has no handshake; it is accepted every cycle.

## Test plan
- Reset (NUM_CH=4, ACC_W=24, LOCK_CYCLES=16) → `locked=0` and `cen=0` for 15 edges after `rst` drops; `locked=1` after the 16th edge; `cen` stays 0 because all `inc` are 0.
- Program ch0 `inc=0x800000`, `phase=0`, then apply → after lock, `cen[0]` pulses exactly every 2 cycles; other channels silent.
- Ch1 `inc=0x400000` `phase=0xC00000`, ch2 `inc=0x400000` `phase=0`, apply → both pulse every 4 cycles, with ch2 lagging ch1 by 3 cycles.
- `cfg_apply` while LOCKED with channels running → `cen` all 0 and `locked=0` for 16 edges; pulses resume at the new rates with phases measured from the apply edge.
- `cfg_we` with `cfg_ch=5` → no shadow changes. Same-cycle `cfg_we` on ch0 (`inc=0x200000`) plus `cfg_apply` → old `inc` is applied; the next apply yields a 1-in-8 rate.
- ACC_W=8, `inc=0xFF` → `cen[0]` high 255 of every 256 cycles. `rst` mid-run → all outputs 0 at the next edge.
